// File: rtl/divider_pkg.sv
`default_nettype none
// ============================================================================
// divider_pkg : shared constants and helpers for the pipelined divider
// Rev 1.0
// ============================================================================
package divider_pkg;

  localparam logic DIV_MODE_UNSIGNED = 1'b0;
  localparam logic DIV_MODE_SIGNED   = 1'b1;
  localparam int   MAX_WIDTH         = 64;

  function automatic int div_latency(input int width);
    return width + 2;
  endfunction

  // Two's-complement magnitude within the low `width` bits; the most negative
  // value maps onto 2^(width-1), which still fits as an unsigned magnitude.
  function automatic logic [MAX_WIDTH-1:0] abs_mag(input logic [MAX_WIDTH-1:0] x,
                                                   input logic is_signed,
                                                   input int width);
    logic [MAX_WIDTH-1:0] mask;
    mask = (width >= MAX_WIDTH) ? '1 : ((MAX_WIDTH'(1) << width) - MAX_WIDTH'(1));
    if (is_signed && x[width-1])
      return (~x + MAX_WIDTH'(1)) & mask;
    return x & mask;
  endfunction

endpackage
`default_nettype wire

// File: rtl/divider_stage.sv
`default_nettype none
// ============================================================================
// divider_stage : one registered restore-subtract iteration
// Rev 1.0
// ============================================================================
module divider_stage
  import divider_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             prev_valid,
  input  logic [WIDTH:0]   prev_rem,
  input  logic [WIDTH-1:0] prev_quo,
  input  logic [WIDTH-1:0] prev_dvd,
  input  logic [WIDTH-1:0] prev_dsr,
  input  logic             prev_q_neg,
  input  logic             prev_r_neg,
  input  logic             prev_zero,
  output logic             next_valid,
  output logic [WIDTH:0]   next_rem,
  output logic [WIDTH-1:0] next_quo,
  output logic [WIDTH-1:0] next_dvd,
  output logic [WIDTH-1:0] next_dsr,
  output logic             next_q_neg,
  output logic             next_r_neg,
  output logic             next_zero
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;
  logic           take;

  // Restoring keeps rem < divisor, so the top remainder bit never feeds the shift.
  assign shifted = {prev_rem[WIDTH-1:0], prev_dvd[WIDTH-1]};
  assign diff    = shifted - {1'b0, prev_dsr};
  assign take    = ~diff[WIDTH];

  always_ff @(posedge clk) begin
    if (!rst_n) next_valid <= 1'b0;
    else        next_valid <= prev_valid;
  end

  always_ff @(posedge clk) begin
    if (prev_valid) begin
      next_rem   <= take ? diff : shifted;
      next_quo   <= {prev_quo[WIDTH-2:0], take};
      next_dvd   <= {prev_dvd[WIDTH-2:0], 1'b0};
      next_dsr   <= prev_dsr;
      next_q_neg <= prev_q_neg;
      next_r_neg <= prev_r_neg;
      next_zero  <= prev_zero;
    end
  end

  logic unused_bits;
  assign unused_bits = prev_rem[WIDTH] ^ prev_quo[WIDTH-1];

endmodule
`default_nettype wire

// File: rtl/streamlined_divider_pipe.sv
`default_nettype none
// ============================================================================
// streamlined_divider_pipe : fully pipelined signed/unsigned restoring divider
// Rev 1.0
// ============================================================================
module streamlined_divider_pipe
  import divider_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int SIGNED_EN = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_sig,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             dong_sig,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] reminder,
  output logic             div_zero
);

  localparam int N_ITER = div_latency(WIDTH) - 2;

  logic                 eff_signed;
  logic [MAX_WIDTH-1:0] dvd_mag_full;
  logic [MAX_WIDTH-1:0] dsr_mag_full;

  assign eff_signed   = (SIGNED_EN != 0) && (signed_mode == DIV_MODE_SIGNED);
  assign dvd_mag_full = abs_mag(MAX_WIDTH'(dividend), eff_signed, WIDTH);
  assign dsr_mag_full = abs_mag(MAX_WIDTH'(divisor),  eff_signed, WIDTH);

  // Input stage registers
  logic             s0_valid;
  logic [WIDTH-1:0] s0_dvd;
  logic [WIDTH-1:0] s0_dsr;
  logic             s0_q_neg;
  logic             s0_r_neg;
  logic             s0_zero;

  always_ff @(posedge clk) begin
    if (!rst_n) s0_valid <= 1'b0;
    else        s0_valid <= start_sig;
  end

  always_ff @(posedge clk) begin
    if (start_sig) begin
      s0_dvd   <= dvd_mag_full[WIDTH-1:0];
      s0_dsr   <= dsr_mag_full[WIDTH-1:0];
      s0_q_neg <= eff_signed && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
      s0_r_neg <= eff_signed && dividend[WIDTH-1];
      s0_zero  <= (divisor == '0);
    end
  end

  logic             v     [0:N_ITER];
  logic [WIDTH:0]   rem   [0:N_ITER];
  logic [WIDTH-1:0] quo   [0:N_ITER];
  logic [WIDTH-1:0] dvd   [0:N_ITER];
  logic [WIDTH-1:0] dsr   [0:N_ITER];
  logic             q_neg [0:N_ITER];
  logic             r_neg [0:N_ITER];
  logic             zero  [0:N_ITER];

  assign v[0]     = s0_valid;
  assign rem[0]   = '0;
  assign quo[0]   = '0;
  assign dvd[0]   = s0_dvd;
  assign dsr[0]   = s0_dsr;
  assign q_neg[0] = s0_q_neg;
  assign r_neg[0] = s0_r_neg;
  assign zero[0]  = s0_zero;

  for (genvar i = 1; i <= N_ITER; i++) begin : g_stage
    divider_stage #(.WIDTH(WIDTH)) u_stage (
      .clk        (clk),
      .rst_n      (rst_n),
      .prev_valid (v[i-1]),
      .prev_rem   (rem[i-1]),
      .prev_quo   (quo[i-1]),
      .prev_dvd   (dvd[i-1]),
      .prev_dsr   (dsr[i-1]),
      .prev_q_neg (q_neg[i-1]),
      .prev_r_neg (r_neg[i-1]),
      .prev_zero  (zero[i-1]),
      .next_valid (v[i]),
      .next_rem   (rem[i]),
      .next_quo   (quo[i]),
      .next_dvd   (dvd[i]),
      .next_dsr   (dsr[i]),
      .next_q_neg (q_neg[i]),
      .next_r_neg (r_neg[i]),
      .next_zero  (zero[i])
    );
  end

  logic [WIDTH-1:0] q_mag;
  logic [WIDTH-1:0] r_mag;

  assign q_mag = quo[N_ITER];
  assign r_mag = rem[N_ITER][WIDTH-1:0];

  // A zero divisor accumulates the dividend magnitude as remainder, so the
  // usual remainder sign fix restores the original dividend.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dong_sig <= 1'b0;
      quotient <= '0;
      reminder <= '0;
      div_zero <= 1'b0;
    end else begin
      dong_sig <= v[N_ITER];
      if (v[N_ITER]) begin
        quotient <= zero[N_ITER] ? '1 : (q_neg[N_ITER] ? -q_mag : q_mag);
        reminder <= r_neg[N_ITER] ? -r_mag : r_mag;
        div_zero <= zero[N_ITER];
      end
    end
  end

  logic unused_bits;
  assign unused_bits = ^{dvd_mag_full, dsr_mag_full, rem[N_ITER][WIDTH],
                         dvd[N_ITER], dsr[N_ITER]};

endmodule
`default_nettype wire

// File: tb/tb_streamlined_divider_pipe.sv
`default_nettype none
// ============================================================================
// tb_streamlined_divider_pipe : scoreboard bench for 4-bit signed and 8-bit unsigned-only dividers
// Rev 1.0
// ============================================================================
module tb_streamlined_divider_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       s4, m4, d4, z4;
  logic [3:0] a4, b4, q4, r4;
  logic       s8, m8, d8, z8;
  logic [7:0] a8, b8, q8, r8;

  streamlined_divider_pipe #(.WIDTH(4), .SIGNED_EN(1)) dut4 (
    .clk(clk), .rst_n(rst_n), .start_sig(s4), .signed_mode(m4),
    .dividend(a4), .divisor(b4), .dong_sig(d4), .quotient(q4),
    .reminder(r4), .div_zero(z4)
  );

  streamlined_divider_pipe #(.WIDTH(8), .SIGNED_EN(0)) dut8 (
    .clk(clk), .rst_n(rst_n), .start_sig(s8), .signed_mode(m8),
    .dividend(a8), .divisor(b8), .dong_sig(d8), .quotient(q8),
    .reminder(r8), .div_zero(z8)
  );

  typedef struct {
    int unsigned edge_n;
    logic [7:0]  q;
    logic [7:0]  r;
    logic        z;
  } exp_t;

  exp_t sb4[$];
  exp_t sb8[$];
  exp_t e4, e8;

  int unsigned cyc = 0;
  int tests = 0;
  int fails = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    tests++;
    if (act !== exp_v) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", nm, act, exp_v, cyc);
    end
  endtask

  // Monitors: every result pulse must match the oldest outstanding request
  always @(negedge clk) begin
    if (d4 === 1'b1) begin
      if (sb4.size() == 0) begin
        tests++; fails++;
        $display("FAIL w4_unexpected_dong: got pulse expected none (edge %0d)", cyc);
      end else begin
        e4 = sb4.pop_front();
        chk("w4_edge",     cyc,          e4.edge_n);
        chk("w4_quotient", 32'(q4),      32'(e4.q[3:0]));
        chk("w4_reminder", 32'(r4),      32'(e4.r[3:0]));
        chk("w4_div_zero", 32'(z4),      32'(e4.z));
      end
    end
  end

  always @(negedge clk) begin
    if (d8 === 1'b1) begin
      if (sb8.size() == 0) begin
        tests++; fails++;
        $display("FAIL w8_unexpected_dong: got pulse expected none (edge %0d)", cyc);
      end else begin
        e8 = sb8.pop_front();
        chk("w8_edge",     cyc,     e8.edge_n);
        chk("w8_quotient", 32'(q8), 32'(e8.q));
        chk("w8_reminder", 32'(r8), 32'(e8.r));
        chk("w8_div_zero", 32'(z8), 32'(e8.z));
      end
    end
  end

  // Result for a request sampled at edge k appears after edge k+WIDTH+1
  task automatic issue4(input logic m, input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] q, input logic [3:0] r, input logic z);
    @(negedge clk);
    s4 = 1'b1; m4 = m; a4 = a; b4 = b;
    sb4.push_back('{cyc + 1 + 5, 8'(q), 8'(r), z});
  endtask

  task automatic issue8(input logic m, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] q, input logic [7:0] r, input logic z);
    @(negedge clk);
    s8 = 1'b1; m8 = m; a8 = a; b8 = b;
    sb8.push_back('{cyc + 1 + 9, q, r, z});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      s4 = 1'b0; s8 = 1'b0;
      a4 = 4'($urandom); b4 = 4'($urandom); m4 = 1'($urandom);
      a8 = 8'($urandom); b8 = 8'($urandom);
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_dong4"}, 32'(d4), 0);
    chk({tag, "_q4"},    32'(q4), 0);
    chk({tag, "_r4"},    32'(r4), 0);
    chk({tag, "_z4"},    32'(z4), 0);
    chk({tag, "_dong8"}, 32'(d8), 0);
    chk({tag, "_q8"},    32'(q8), 0);
    chk({tag, "_r8"},    32'(r8), 0);
    chk({tag, "_z8"},    32'(z8), 0);
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && (sb4.size() != 0 || sb8.size() != 0); i++)
      @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    s4 = 0; m4 = 0; a4 = 0; b4 = 0;
    s8 = 0; m8 = 0; a8 = 0; b8 = 0;
    repeat (2) @(posedge clk);
    #1 check_zero_outputs("reset");
    @(negedge clk) rst_n = 1'b1;

    // unsigned 7/2, isolated
    issue4(1'b0, 4'd7, 4'd2, 4'd3, 4'd1, 1'b0);
    idle(8);

    // back-to-back stream
    issue4(1'b0, 4'd15, 4'd4, 4'd3, 4'd3, 1'b0);
    issue4(1'b0, 4'd9,  4'd3, 4'd3, 4'd0, 1'b0);
    issue4(1'b0, 4'd0,  4'd5, 4'd0, 4'd0, 1'b0);
    // divide by zero
    issue4(1'b0, 4'd13,   4'd0, 4'b1111, 4'd13,   1'b1);
    issue4(1'b1, 4'b1101, 4'd0, 4'b1111, 4'b1101, 1'b1);
    // signed cases
    issue4(1'b1, 4'b1001, 4'b0010, 4'b1101, 4'b1111, 1'b0);
    issue4(1'b1, 4'b0111, 4'b1110, 4'b1101, 4'b0001, 1'b0);
    issue4(1'b1, 4'b1000, 4'b1111, 4'b1000, 4'b0000, 1'b0);
    issue4(1'b1, 4'b1000, 4'b0011, 4'b1110, 4'b1110, 1'b0);
    // same bit pattern unsigned: 9/2
    issue4(1'b0, 4'b1001, 4'b0010, 4'd4, 4'd1, 1'b0);
    idle(1);
    // operands wiggle while idle; no results may appear
    idle(6);
    drain(20);

    // reset mid-flight
    issue4(1'b0, 4'd1, 4'd1, 4'd1, 4'd0, 1'b0);
    issue4(1'b0, 4'd2, 4'd1, 4'd2, 4'd0, 1'b0);
    issue4(1'b0, 4'd3, 4'd1, 4'd3, 4'd0, 1'b0);
    idle(1);
    @(negedge clk);
    rst_n = 1'b0;
    sb4.delete();
    @(posedge clk);
    #1 check_zero_outputs("midreset");
    @(negedge clk) rst_n = 1'b1;
    idle(10);
    issue4(1'b0, 4'd6, 4'd3, 4'd2, 4'd0, 1'b0);
    idle(1);
    drain(20);

    // 8-bit unsigned-only instance: signed_mode ignored
    issue8(1'b1, 8'd200, 8'd7,  8'd28,  8'd4,  1'b0);
    issue8(1'b1, 8'd255, 8'd16, 8'd15,  8'd15, 1'b0);
    issue8(1'b1, 8'h80,  8'hFF, 8'd0,   8'h80, 1'b0);
    issue8(1'b0, 8'd99,  8'd0,  8'hFF,  8'd99, 1'b1);
    idle(1);
    drain(30);

    chk("sb4_empty", 32'(sb4.size()), 0);
    chk("sb8_empty", 32'(sb8.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/streamlined_divider_pipe.md
Name: streamlined_divider_pipe

Overview:
- Parametrised, fully pipelined restoring divider. Generational successor to the fixed 4-bit streamlined divider.
- Accepts one operand pair per clock on start_sig and returns quotient/reminder with fixed latency, flagged by a one-cycle dong_sig pulse.
- Adds over the previous generation:
  - generic WIDTH;
  - per-request signed/unsigned mode;
  - explicit divide-by-zero flag;
  - back-to-back throughput.
- Sits between control FSMs and arithmetic datapaths. No backpressure: consumers must accept results when they arrive.

Parameters:
- WIDTH, 4, operand/result width in bits (>=2).
- SIGNED_EN, 1, 1 = signed_mode honoured; 0 = signed_mode ignored, all divides unsigned (sign logic removed).

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- start_sig  input  1  request valid; operands sampled on every edge where high.
- signed_mode  input  1  1 = two's-complement divide for this request; sampled with start_sig.
- dividend  input  WIDTH  numerator.
- divisor  input  WIDTH  denominator.
- dong_sig  output  1  one-cycle result-valid pulse per accepted request.
- quotient  output  WIDTH  result quotient; valid while dong_sig=1.
- reminder  output  WIDTH  result remainder; valid while dong_sig=1.
- div_zero  output  1  divisor was 0 for this result; valid while dong_sig=1.

Behaviour:
- Reset: rst_n=0 at a rising edge clears every stage valid bit, dong_sig, quotient, reminder and div_zero to 0 on that edge.
  - Reset mid-operation discards all in-flight requests. No dong_sig pulse for them after reset releases.
- Pipeline, for a request sampled at edge k:
  - Input stage (edge k): register mode. If signed, register |dividend| and |divisor| as WIDTH-bit unsigned magnitudes; -2^(WIDTH-1) maps to 2^(WIDTH-1). Also register q_neg = sign(dividend) XOR sign(divisor), r_neg = sign(dividend), and zero = (divisor==0).
  - Iteration stages 1..WIDTH (edges k+1..k+WIDTH): stage i shifts the partial remainder left, brings in the next dividend MSB, and trial-subtracts the divisor magnitude. If non-negative, keep the difference and set the quotient bit to 1; otherwise restore and set the bit to 0. Each stage is a register boundary; partial remainder is WIDTH+1 bits.
  - Output stage (edge k+WIDTH+1): apply sign correction:
    - quotient = q_neg ? -q : q
    - reminder = r_neg ? -r : r
  - dong_sig=1 for exactly the cycle after edge k+WIDTH+1. Total latency WIDTH+2 edges inclusive of the sampling edge.
- Throughput: start_sig may be high on consecutive edges. Each sampled request yields exactly one dong_sig pulse, in order, spaced as the inputs were. No internal stall.
- Outputs hold their last values when dong_sig=0. They are only meaningful when dong_sig=1.
- Divide by zero: div_zero=1, quotient = all ones, reminder = original dividend (sign-preserved), regardless of mode. No sign correction is applied to quotient in this case.
- Signed overflow (-2^(WIDTH-1) / -1): quotient = -2^(WIDTH-1) (wraps), reminder=0, div_zero=0.
- Signed remainder takes the sign of the dividend; quotient truncates toward zero.
- Operand changes while start_sig=0 have no effect.

Decomposition:
- Shared package divider_pkg:
  - DIV_MODE_UNSIGNED/DIV_MODE_SIGNED constants.
  - Function div_latency(WIDTH) = WIDTH+2.
  - Function abs_mag(x, signed) for the magnitude conversion.
- One sub-module: divider_stage, a single registered restore-subtract iteration, instantiated WIDTH times via generate. Carries valid, partial remainder, partial quotient, shifted dividend, divisor magnitude, q_neg, r_neg and zero.

Test Plan:
- WIDTH=4, unsigned 7/2, start_sig pulsed at edge k -> dong_sig pulse after edge k+5; quotient=3, reminder=1, div_zero=0.
- Back-to-back on consecutive edges: 15/4, 9/3, 0/5 -> three consecutive dong_sig pulses; (3,3), (3,0), (0,0).
- Divide by zero, unsigned 13/0 -> div_zero=1, quotient=4'b1111, reminder=13. Signed -3/0 -> quotient=4'b1111, reminder=4'b1101.
- Signed -7/2 -> quotient=4'b1101 (-3), reminder=4'b1111 (-1). Signed 7/-2 -> quotient=-3, reminder=+1. Signed -8/-1 -> quotient=4'b1000, reminder=0, div_zero=0.
- Reset mid-flight: issue 3 requests, drop rst_n for one edge two cycles later -> all outputs 0 and no dong_sig pulse. A new 6/3 issued after release -> correct (2,0) at nominal latency.
- WIDTH=8, SIGNED_EN=0: 200/7 with signed_mode=1 -> quotient=28, reminder=4 (mode ignored), latency 10 edges.
